// File: rtl/uart_pkg.sv
// +--------------------------------------------------------------------------+
// | uart_pkg : shared types and elaboration helpers for the uart_rx receiver |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic int cycles_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic bit params_ok(input int cpb, input int data_bits,
                                   input int stop_bits, input int fifo_depth,
                                   input int parity_odd);
    return (cpb >= 4) &&
           (data_bits >= 5) && (data_bits <= 9) &&
           (stop_bits >= 1) && (stop_bits <= 2) &&
           (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0) &&
           ((parity_odd == 0) || (parity_odd == 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// +--------------------------------------------------------------------------+
// | uart_rx_fifo : small synchronous FIFO with show-ahead read for uart_rx   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot being written.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// +--------------------------------------------------------------------------+
// | uart_rx : parametrised async serial receiver with output FIFO            |
// | Optional parity via macro UART_RX_PARITY_EN.                             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 10_000_000,
  parameter int BAUD       = 31_250,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_i,
  input  logic                 nrst_i,
  input  logic                 rxData_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic                 frameErr_o,
  output logic                 parityErr_o,
  output logic                 overrun_o
);

  localparam int             CPB       = cycles_per_bit(CLK_HZ, BAUD);
  localparam int             CW        = $clog2(CPB);
  localparam logic [CW-1:0]  CNT_HALF  = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CPB - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

  generate
    if (!params_ok(CPB, DATA_BITS, STOP_BITS, FIFO_DEPTH, PARITY_ODD)) begin : g_param_check
      $error("uart_rx: parameter out of range");
    end
  endgenerate

  logic                 sync1;
  logic                 rx_sync;
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_bad;
  logic                 busy;
  logic                 frame_err;
  logic                 overrun;
  logic                 frame_done;
  logic                 bad_stop;
  logic                 par_bad;
  logic                 good;
  logic                 pop;
  logic                 push;
  logic                 fifo_empty;
  logic                 fifo_full;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sync1   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      sync1   <= rxData_i;
      rx_sync <= sync1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic parity_err;
  assign par_bad     = (par_bit != ((^shreg) ^ (PARITY_ODD != 0)));
  assign parityErr_o = parity_err;
`else
  assign par_bad     = 1'b0;
  assign parityErr_o = 1'b0;
`endif

  assign frame_done = (state == ST_STOP) && (cnt == CNT_LAST) && (bit_cnt == STOP_LAST);
  assign bad_stop   = stop_bad || !rx_sync;
  assign good       = frame_done && !bad_stop && !par_bad;
  assign pop        = !fifo_empty && ready_i;
  assign push       = good && (!fifo_full || pop);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      stop_bad  <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          cnt      <= '0;
          bit_cnt  <= '0;
          stop_bad <= 1'b0;
          if (!rx_sync) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_sync) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= ST_PARITY;
`else
              state   <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_sync;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            // Leave mid-stop-bit so a following start edge is never missed.
            if (bit_cnt == STOP_LAST) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              frame_err <= bad_stop;
              overrun   <= good && fifo_full && !pop;
`ifdef UART_RX_PARITY_EN
              parity_err <= !bad_stop && par_bad;
`endif
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              stop_bad <= bad_stop;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .nrst_i (nrst_i),
    .push   (push),
    .wdata  (shreg),
    .pop    (pop),
    .rdata  (data_o),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  assign valid_o    = !fifo_empty;
  assign busy_o     = busy;
  assign frameErr_o = frame_err;
  assign overrun_o  = overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// +--------------------------------------------------------------------------+
// | tb_uart_rx : self-checking bench for uart_rx (CPB = 16, 8 data, 1 stop)  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx;

  localparam int CLK_HZ     = 16;
  localparam int BAUD       = 1;
  localparam int CPB        = CLK_HZ / BAUD;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int PARITY_ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  // Edges from the first edge that sees the line low to the push edge.
  localparam int LATENCY = 2 + CPB / 2 + CPB * (DATA_BITS + PAR_EN + STOP_BITS);

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       ferr;
  logic       perr;
  logic       ovr;

  int checks = 0;
  int fails  = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int ovr_cnt  = 0;
  logic [7:0] got [$];

  uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .DATA_BITS  (DATA_BITS),
    .STOP_BITS  (STOP_BITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk_i       (clk),
    .nrst_i      (nrst),
    .rxData_i    (rx),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .busy_o      (busy),
    .frameErr_o  (ferr),
    .parityErr_o (perr),
    .overrun_o   (ovr)
  );

  always #5 clk = ~clk;

  // Observe accepted words and error pulses away from the active edge.
  always @(negedge clk) begin
    if (nrst) begin
      if (valid && ready) got.push_back(data);
      if (ferr) ferr_cnt++;
      if (perr) perr_cnt++;
      if (ovr)  ovr_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got.delete();
    ferr_cnt = 0;
    perr_cnt = 0;
    ovr_cnt  = 0;
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    if (PAR_EN != 0) begin
      rx = par_v;
      tick(CPB);
    end
    rx = stop_v;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; rx = 1'b1; ready = 1'b0;
    tick(3);
    checks++; if (data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ferr !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", ferr); end
    checks++; if (perr !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b want 0", perr); end
    checks++; if (ovr !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %b want 0", ovr); end
    nrst = 1'b1;
    tick(4);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int n;
    logic [7:0] cap;
    logic v_next;
    clear_mon();
    ready = 1'b1;
    n = 0; cap = '0; v_next = 1'b1;
    fork
      send_frame(8'hA5, 1'b1, good_par(8'hA5));
      begin
        @(posedge clk);
        while (valid !== 1'b1 && n < 400) begin
          @(posedge clk); #1; n++;
        end
        cap = data;
        @(posedge clk); #1;
        v_next = valid;
      end
    join
    tick(2 * CPB);
    checks++; if (n !== LATENCY) begin fails++; $display("FAIL single_latency: got %0d want %0d", n, LATENCY); end
    checks++; if (cap !== 8'hA5) begin fails++; $display("FAIL single_data: got %h want a5", cap); end
    checks++; if (v_next !== 1'b0) begin fails++; $display("FAIL single_valid_pulse: got %b want 0", v_next); end
    checks++; if (got.size() !== 1) begin fails++; $display("FAIL single_count: got %0d want 1", got.size()); end
    checks++; if ((ferr_cnt + perr_cnt + ovr_cnt) !== 0) begin fails++; $display("FAIL single_pulses: got %0d want 0", ferr_cnt + perr_cnt + ovr_cnt); end
  endtask

  task automatic test_glitch();
    int b;
    clear_mon();
    ready = 1'b1;
    b = 0;
    rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (i == 4) rx = 1'b1;
      if (busy) b++;
    end
    checks++; if (!(b > 0 && b <= CPB / 2)) begin fails++; $display("FAIL glitch_busy_cycles: got %0d want 1..%0d", b, CPB / 2); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_idle: got %b want 0", busy); end
    checks++; if (got.size() !== 0) begin fails++; $display("FAIL glitch_push: got %0d want 0", got.size()); end
    checks++; if ((ferr_cnt + perr_cnt + ovr_cnt) !== 0) begin fails++; $display("FAIL glitch_pulses: got %0d want 0", ferr_cnt + perr_cnt + ovr_cnt); end
  endtask

  task automatic test_frame_err();
    clear_mon();
    ready = 1'b1;
    send_frame(8'h3C, 1'b0, good_par(8'h3C));
    tick(2 * CPB);
    checks++; if (ferr_cnt !== 1) begin fails++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt); end
    checks++; if (got.size() !== 0) begin fails++; $display("FAIL ferr_push: got %0d want 0", got.size()); end
    checks++; if (perr_cnt !== 0) begin fails++; $display("FAIL ferr_perr: got %0d want 0", perr_cnt); end
    send_frame(8'h11, 1'b1, good_par(8'h11));
    tick(CPB);
    checks++; if (got.size() !== 1) begin fails++; $display("FAIL ferr_next_count: got %0d want 1", got.size()); end
    else begin
      checks++; if (got[0] !== 8'h11) begin fails++; $display("FAIL ferr_next_data: got %h want 11", got[0]); end
    end
    checks++; if (ferr_cnt !== 1) begin fails++; $display("FAIL ferr_after: got %0d want 1", ferr_cnt); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp [$];
    int exp_ovr;
    clear_mon();
    ready = 1'b0;
    exp_ovr = 0;
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 1'b1, good_par(8'(v)));
      if (exp.size() < FIFO_DEPTH) exp.push_back(8'(v));
      else exp_ovr++;
    end
    tick(CPB);
    checks++; if (ovr_cnt !== exp_ovr) begin fails++; $display("FAIL ovr_pulses: got %0d want %0d", ovr_cnt, exp_ovr); end
    checks++; if (valid !== 1'b1 || data !== exp[0]) begin fails++; $display("FAIL ovr_head: got %b/%h want 1/%h", valid, data, exp[0]); end
    tick(5);
    checks++; if (data !== exp[0]) begin fails++; $display("FAIL ovr_stable: got %h want %h", data, exp[0]); end
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      ready = 1'b1; tick(1);
      ready = 1'b0; tick(1);
    end
    checks++; if (got.size() !== exp.size()) begin fails++; $display("FAIL ovr_count: got %0d want %0d", got.size(), exp.size()); end
    else begin
      for (int k = 0; k < exp.size(); k++) begin
        checks++; if (got[k] !== exp[k]) begin fails++; $display("FAIL ovr_order[%0d]: got %h want %h", k, got[k], exp[k]); end
      end
    end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL ovr_drained: got %b want 0", valid); end
  endtask

  task automatic test_parity();
    clear_mon();
    ready = 1'b1;
    send_frame(8'h07, 1'b1, good_par(8'h07));
    tick(CPB);
    checks++; if (got.size() !== 1 || perr_cnt !== 0) begin fails++; $display("FAIL par_ok: got %0d words %0d perr want 1/0", got.size(), perr_cnt); end
    send_frame(8'h07, 1'b1, ~good_par(8'h07));
    tick(CPB);
    checks++; if (perr_cnt !== 1) begin fails++; $display("FAIL par_bad_pulse: got %0d want 1", perr_cnt); end
    checks++; if (got.size() !== 1 || ferr_cnt !== 0) begin fails++; $display("FAIL par_bad_push: got %0d words %0d ferr want 1/0", got.size(), ferr_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    ready = 1'b0;
    send_frame(8'h33, 1'b1, good_par(8'h33));
    tick(4);
    checks++; if (valid !== 1'b1) begin fails++; $display("FAIL rmid_pre_valid: got %b want 1", valid); end
    fork
      send_frame(8'hF0, 1'b1, good_par(8'hF0));
      begin
        tick(CPB * 5 + CPB / 2);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rmid_pre_busy: got %b want 1", busy); end
        nrst = 1'b0;
        #1;
        checks++; if ({data, valid, busy, ferr, perr, ovr} !== 13'd0) begin fails++; $display("FAIL rmid_outputs: got %h/%b%b%b%b%b want all 0", data, valid, busy, ferr, perr, ovr); end
      end
    join
    tick(4);
    nrst = 1'b1;
    tick(4);
    clear_mon();
    ready = 1'b1;
    send_frame(8'h5A, 1'b1, good_par(8'h5A));
    tick(CPB);
    checks++; if (got.size() !== 1) begin fails++; $display("FAIL rmid_after_count: got %0d want 1", got.size()); end
    else begin
      checks++; if (got[0] !== 8'h5A) begin fails++; $display("FAIL rmid_after_data: got %h want 5a", got[0]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp [$];
    int exp_ferr, exp_perr;
    logic [7:0] d;
    logic bad_stop, bad_par;
    clear_mon();
    ready = 1'b1;
    exp_ferr = 0; exp_perr = 0;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      bad_stop = ($urandom_range(0, 5) == 0);
      bad_par  = (PAR_EN != 0) && ($urandom_range(0, 5) == 0);
      send_frame(d, ~bad_stop, good_par(d) ^ bad_par);
      if (bad_stop)     exp_ferr++;
      else if (bad_par) exp_perr++;
      else              exp.push_back(d);
      if (bad_stop) tick(2 * CPB);
      else          tick($urandom_range(0, CPB));
    end
    tick(2 * CPB);
    checks++; if (got.size() !== exp.size()) begin fails++; $display("FAIL rand_count: got %0d want %0d", got.size(), exp.size()); end
    else begin
      for (int k = 0; k < exp.size(); k++) begin
        checks++; if (got[k] !== exp[k]) begin fails++; $display("FAIL rand_data[%0d]: got %h want %h", k, got[k], exp[k]); end
      end
    end
    checks++; if (ferr_cnt !== exp_ferr) begin fails++; $display("FAIL rand_ferr: got %0d want %0d", ferr_cnt, exp_ferr); end
    checks++; if (perr_cnt !== exp_perr) begin fails++; $display("FAIL rand_perr: got %0d want %0d", perr_cnt, exp_perr); end
    checks++; if (ovr_cnt !== 0) begin fails++; $display("FAIL rand_ovr: got %0d want 0", ovr_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    if (PAR_EN != 0) test_parity();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Parametrised asynchronous serial receiver, successor to the fixed 31250-baud MIDI front end. It supports configurable clock/baud ratio, data width, stop-bit count, start-bit glitch rejection, framing-error detection, optional parity and an output FIFO with a valid/ready handshake. It sits between the `rxData_i` pad and the MIDI parser, and can be reused for any 8N1-style serial input.

## Interface
- `CLK_HZ`, 10_000_000, system clock frequency.
- `BAUD`, 31_250, bit rate; `CPB = CLK_HZ/BAUD` (integer division), must be ≥ 4.
- `DATA_BITS`, 8, payload bits per frame, range 5..9.
- `STOP_BITS`, 1, stop bits checked, range 1..2.
- `FIFO_DEPTH`, 4, output FIFO entries, power of two, ≥ 2.
- `PARITY_ODD`, 0, 1 = odd parity, 0 = even parity. Used only when parity is compiled in.
- `clk_i`  in  1  system clock.
- `nrst_i`  in  1  asynchronous active-low reset.
- `rxData_i`  in  1  serial line, idle high, asynchronous.
- `data_o`  out  DATA_BITS  FIFO head word.
- `valid_o`  out  1  FIFO not empty.
- `ready_i`  in  1  consumer accepts `data_o`.
- `busy_o`  out  1  FSM not in IDLE.
- `frameErr_o`  out  1  one-cycle pulse: a stop bit was sampled low.
- `parityErr_o`  out  1  one-cycle pulse: parity mismatch.
- `overrun_o`  out  1  one-cycle pulse: a good frame was dropped because the FIFO was full.

## Operation
- **Input synchroniser:** two flops on `rxData_i`, both reset to 1. All logic uses the second flop, `rxSync`.
- **Counter:** `cycleCnt`, width `$clog2(CPB)`.
  - Cleared in IDLE.
  - Cleared at every sample point.
  - Increments otherwise.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** when `rxSync` = 0, go to START.
  - **START:** at `cycleCnt == CPB/2-1`:
    - `rxSync` = 0 → DATA.
    - `rxSync` = 1 → IDLE (glitch rejected, nothing else flagged).
  - **DATA:** sample at `cycleCnt == CPB-1`. Shift LSB-first: the sample enters the MSB and the word shifts right. After `DATA_BITS` samples go to PARITY if compiled in, else STOP.
  - **PARITY:** one sample at `CPB-1`, then STOP.
  - **STOP:** `STOP_BITS` samples at `CPB-1`. After the last sample return to IDLE immediately (half a bit early), which allows back-to-back frames.
- **Frame completion**, evaluated at the last stop sample:
  - Any stop sample was 0 → `frameErr_o` pulses, word discarded.
  - Else parity mismatch → `parityErr_o` pulses, word discarded.
  - Both conditions true → only `frameErr_o` pulses.
  - Else, FIFO not full, or full with a pop in the same cycle → push.
  - Else (full, no pop) → word dropped, `overrun_o` pulses.
- **Handshake:**
  - Pop occurs on an edge where `valid_o && ready_i`.
  - `data_o` is stable while `valid_o` is high and no pop occurs.
  - Push and pop in the same cycle are both performed; the count is unchanged.
- **Line held low after a frame (break):** STOP flags a frame error, IDLE then sees 0 and starts a new frame. This is a repeated frame error, not a lockup.
- **Reset** at any time, including mid-frame:
  - FSM to IDLE, counters 0, FIFO empty.
  - `data_o` = 0; `valid_o`, `busy_o`, `frameErr_o`, `parityErr_o`, `overrun_o` = 0.

## Timing
- Synchroniser latency: 2 cycles.
- From the first `rxSync` low cycle to the push edge: `CPB/2 + CPB·(DATA_BITS + P + STOP_BITS)` cycles, where P = 1 with parity, else 0.
- `valid_o` rises the cycle after the push edge. Error pulses are registered and assert that same cycle.
- `busy_o` is registered from the state.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. An explicit count (one bit wider) distinguishes full from empty.
- Pop-to-next-word: the new head appears on `data_o` the cycle after the pop edge.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:** PARITY state present. Expected parity is `^word ^ PARITY_ODD` and must equal the received parity bit.
- **Undefined:** no PARITY state or parity logic. `parityErr_o` is tied to 0 and `PARITY_ODD` is ignored. The port list is unchanged.

## Structure
- **Package `uart_pkg`:**
  - FSM state typedef (3-bit enum).
  - `cycles_per_bit(clk, baud)` constant function.
  - Parameter range assertions helper.
- **Sub-module `uart_rx_fifo`:**
  - Parameters: `WIDTH`, `DEPTH`.
  - Ports: `push`, `wdata`, `pop`, `rdata`, `empty`, `full`.
  - Same clock and reset as the parent.
  - Storage resets to 0.

## Test plan
Bench uses `CLK_HZ=16`, `BAUD=1` (`CPB=16`), `DATA_BITS=8`, `STOP_BITS=1`, `FIFO_DEPTH=4`.
- **Single frame:** send 0xA5 (8N1), `ready_i`=1 → `valid_o` pulses for one cycle with `data_o`=0xA5, no error pulses. Measured latency is `2 + 8 + 16·9` cycles from the `rxData_i` falling edge.
- **Glitch:** `rxData_i` low for 5 cycles → `busy_o` high for ≤ 8 cycles, then IDLE; nothing pushed and no pulses.
- **Framing error:** send 0x3C with the stop bit = 0 → `frameErr_o` pulses once, `valid_o` stays 0, and the next valid frame 0x11 is received correctly.
- **Overrun:** send 0x01..0x05 with `ready_i`=0 → FIFO holds 0x01–0x04 and `overrun_o` pulses on the fifth frame. Popping yields 0x01, 0x02, 0x03, 0x04 in order.
- **Parity** (with `UART_RX_PARITY_EN`, `PARITY_ODD`=0):
  - 0x07 with parity bit 1 → accepted.
  - 0x07 with parity bit 0 → `parityErr_o` pulse, no push.
- **Reset mid-frame:** assert `nrst_i` low during data bit 4 of 0xF0 → all outputs 0 immediately. After release, a fresh frame 0x5A is received intact.
